// File: rtl/nested_read_port_if.sv
`default_nettype none
// ============================================================================
// Module  : nested_read_port_if
// Purpose : Config, SRAM read and output stream bundle for nested_read_port.
// Rev     : 1.0  initial release
// ============================================================================
interface nested_read_port_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] offset;
  logic [15:0]       x_max;
  logic [15:0]       y_max;
  logic [ADDR_W-1:0] x_stride;
  logic [ADDR_W-1:0] y_stride_op;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output start, offset, x_max, y_max, x_stride, y_stride_op, mem_rd_data, out_ready,
    input  busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
  );

  modport slave (
    input  start, offset, x_max, y_max, x_stride, y_stride_op, mem_rd_data, out_ready,
    output busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/nested_read_port.sv
`default_nettype none
// ============================================================================
// Module  : nested_read_port
// Purpose : 2-D affine SRAM read walker with credit-throttled FWFT output FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module nested_read_port #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  nested_read_port_if.slave  bus
);
  localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [1:0]         c_idle    = 2'd0;
  localparam logic [1:0]         c_run     = 2'd1;
  localparam logic [1:0]         c_drain   = 2'd2;
  localparam logic [c_ptr_w+1:0] c_depth   = (c_ptr_w+2)'(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w+1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [1:0]             r_state;
  logic [ADDR_W-1:0]      r_offset, r_x_stride, r_y_stride_op, r_acc;
  logic [15:0]            r_x_max, r_y_max, r_xc, r_yc;
  logic                   r_inflight, r_inflight_last, r_done;
  logic [DATA_W-1:0]      r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  r_fifo_last;
  logic [c_ptr_w-1:0]     r_wr_ptr, r_rd_ptr;
  logic [c_ptr_w:0]       r_count;

  logic                   w_issue, w_push, w_pop, w_valid;
  logic                   w_x_end, w_y_end, w_zero;
  logic [c_ptr_w+1:0]     w_credit_used;

  // Only the registered count is credited, so a same-cycle pop never lets a read slip in early.
  assign w_credit_used = {1'b0, r_count} + (c_ptr_w+2)'(r_inflight);
  assign w_issue       = (r_state == c_run) && (w_credit_used < c_depth);
  assign w_x_end       = (r_xc == r_x_max - 16'd1);
  assign w_y_end       = (r_yc == r_y_max - 16'd1);
  assign w_zero        = (bus.x_max == 16'd0) || (bus.y_max == 16'd0);
  assign w_valid       = (r_count != '0);
  assign w_push        = r_inflight;
  assign w_pop         = w_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= c_idle;
      r_offset        <= '0;
      r_x_stride      <= '0;
      r_y_stride_op   <= '0;
      r_acc           <= '0;
      r_x_max         <= '0;
      r_y_max         <= '0;
      r_xc            <= '0;
      r_yc            <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_x_end && w_y_end;
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_offset      <= bus.offset;
            r_x_max       <= bus.x_max;
            r_y_max       <= bus.y_max;
            r_x_stride    <= bus.x_stride;
            r_y_stride_op <= bus.y_stride_op;
            r_xc          <= '0;
            r_yc          <= '0;
            r_acc         <= '0;
            if (w_zero) r_done  <= 1'b1;
            else        r_state <= c_run;
          end
        end
        c_run: begin
          if (w_issue) begin
            if (w_x_end && w_y_end) begin
              r_state <= c_drain;
            end else if (w_x_end) begin
              r_xc  <= '0;
              r_yc  <= r_yc + 16'd1;
              r_acc <= r_acc + r_y_stride_op;
            end else begin
              r_xc  <= r_xc + 16'd1;
              r_acc <= r_acc + r_x_stride;
            end
          end
        end
        c_drain: begin
          if (w_pop && r_fifo_last[r_rd_ptr]) begin
            r_state <= c_idle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.mem_rd_data;
      r_fifo_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  assign bus.busy      = (r_state != c_idle);
  assign bus.done      = r_done;
  assign bus.mem_rd_en = w_issue;
  assign bus.mem_addr  = r_offset + r_acc;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.out_last  = w_valid & r_fifo_last[r_rd_ptr];
endmodule
`default_nettype wire

// File: tb/tb_nested_read_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_nested_read_port
// Purpose : Directed and randomized checks of nested_read_port against a closed-form model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nested_read_port;
  localparam int c_depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  nested_read_port_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  nested_read_port #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(c_depth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency, junk on idle cycles.
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? (bus.mem_addr ^ 16'hA5A5) : 16'($urandom);

  logic [15:0] q_addr [$];
  int          q_rd_cyc [$];
  logic [15:0] q_data [$];
  logic        q_last [$];
  int          q_acc_cyc [$];
  int          q_done_cyc [$];
  bit          busy_seen, valid_seen;
  int          first_valid_cyc;
  int          occ = 0;
  bit          prev_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Occupancy scoreboard: a beat lands one cycle after its read, leaves on handshake.
  always @(negedge clk) begin
    if (rst) begin
      occ     = 0;
      prev_rd = 0;
    end else begin
      chk("out_valid_vs_occupancy", 32'(bus.out_valid), 32'(occ != 0));
      if (bus.mem_rd_en) begin
        q_addr.push_back(bus.mem_addr);
        q_rd_cyc.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(bus.out_data);
        q_last.push_back(bus.out_last);
        q_acc_cyc.push_back(cyc);
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.busy) busy_seen = 1;
      if (bus.out_valid) valid_seen = 1;
      if (bus.done) q_done_cyc.push_back(cyc);
      occ = occ + int'(prev_rd) - int'(bus.out_valid && bus.out_ready);
      if (prev_rd) chk("fifo_no_overflow", 32'(occ <= c_depth), 32'd1);
      prev_rd = bus.mem_rd_en;
    end
  end

  task automatic clear_log();
    q_addr.delete(); q_rd_cyc.delete(); q_data.delete();
    q_last.delete(); q_acc_cyc.delete(); q_done_cyc.delete();
    busy_seen = 0; valid_seen = 0; first_valid_cyc = -1;
  endtask

  // mode 0: always ready, 1: ready low 10 cycles after start, 2: random ready
  task automatic run_frame(input string tag, input logic [15:0] off, input logic [15:0] xm,
                           input logic [15:0] ym, input logic [15:0] xs, input logic [15:0] ys,
                           input int mode, input bit ign);
    logic [15:0] exp_a [$];
    logic [31:0] row_step, a;
    int          start_cyc, n;
    row_step = (32'(xm) - 32'd1) * 32'(xs) + 32'(ys);
    for (int y = 0; y < int'(ym); y++)
      for (int x = 0; x < int'(xm); x++) begin
        a = 32'(off) + 32'(y) * row_step + 32'(x) * 32'(xs);
        exp_a.push_back(a[15:0]);
      end
    n = exp_a.size();
    @(posedge clk); #1;
    clear_log();
    bus.offset = off; bus.x_max = xm; bus.y_max = ym;
    bus.x_stride = xs; bus.y_stride_op = ys;
    bus.out_ready = (mode != 1);
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.offset = 16'($urandom); bus.x_max = 16'($urandom); bus.y_max = 16'($urandom);
    bus.x_stride = 16'($urandom); bus.y_stride_op = 16'($urandom);
    for (int i = 0; i < 600 && q_done_cyc.size() == 0; i++) begin
      if (mode == 1) begin
        if (i == 10) begin
          chk({tag, " reads_while_stalled"}, 32'(q_addr.size()), 32'(c_depth));
          chk({tag, " rd_en_held_low"}, 32'(bus.mem_rd_en), 32'd0);
        end
        bus.out_ready = (i >= 10);
      end else if (mode == 2) begin
        bus.out_ready = ($urandom_range(3) != 0);
      end
      bus.start = ign && (i == 3);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " done_pulses"}, 32'(q_done_cyc.size()), 32'd1);
    chk({tag, " read_count"}, 32'(q_addr.size()), 32'(n));
    chk({tag, " beat_count"}, 32'(q_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < q_addr.size()) chk($sformatf("%s addr[%0d]", tag, i), 32'(q_addr[i]), 32'(exp_a[i]));
      if (i < q_data.size()) begin
        chk($sformatf("%s data[%0d]", tag, i), 32'(q_data[i]), 32'(exp_a[i] ^ 16'hA5A5));
        chk($sformatf("%s last[%0d]", tag, i), 32'(q_last[i]), 32'(i == n - 1));
      end
    end
    if (n == 0) begin
      if (q_done_cyc.size() > 0) chk({tag, " done_latency"}, 32'(q_done_cyc[0] - start_cyc), 32'd1);
      chk({tag, " busy_never"}, 32'(busy_seen), 32'd0);
      chk({tag, " valid_never"}, 32'(valid_seen), 32'd0);
    end else if (q_done_cyc.size() > 0 && q_acc_cyc.size() == n) begin
      chk({tag, " done_after_last_accept"}, 32'(q_done_cyc[0] - q_acc_cyc[n-1]), 32'd1);
    end
    if (mode == 0 && n > 0 && q_rd_cyc.size() == n) begin
      chk({tag, " first_read_latency"}, 32'(q_rd_cyc[0] - start_cyc), 32'd1);
      chk({tag, " reads_back_to_back"}, 32'(q_rd_cyc[n-1] - start_cyc), 32'(n));
      chk({tag, " first_valid_latency"}, 32'(first_valid_cyc - start_cyc), 32'd3);
    end
    chk({tag, " busy_after_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.offset = 0; bus.x_max = 0; bus.y_max = 0;
    bus.x_stride = 0; bus.y_stride_op = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset out_last", 32'(bus.out_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame("3x2_ready", 16'h0100, 16'd3, 16'd2, 16'd1, 16'd5, 0, 1'b0);
    run_frame("3x2_stall", 16'h0100, 16'd3, 16'd2, 16'd1, 16'd5, 1, 1'b0);
    run_frame("zero_size", 16'h1234, 16'd0, 16'd5, 16'd1, 16'd1, 0, 1'b0);
    run_frame("addr_wrap", 16'hFFFE, 16'd4, 16'd1, 16'd1, 16'd0, 0, 1'b0);

    // Abort a frame after two accepted beats.
    @(posedge clk); #1;
    clear_log();
    bus.offset = 16'h0100; bus.x_max = 16'd3; bus.y_max = 16'd2;
    bus.x_stride = 16'd1; bus.y_stride_op = 16'd5; bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 50 && q_data.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("abort two_beats_before_reset", 32'(q_data.size()), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("abort mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort out_data", 32'(bus.out_data), 32'd0);
    chk("abort out_last", 32'(bus.out_last), 32'd0);
    @(negedge clk);
    chk("abort return_discarded", 32'(bus.out_valid), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort no_done", 32'(q_done_cyc.size()), 32'd0);

    run_frame("after_abort_ignored_start", 16'h0100, 16'd3, 16'd2, 16'd1, 16'd5, 0, 1'b1);
    run_frame("1x1", 16'h4321, 16'd1, 16'd1, 16'd7, 16'd9, 0, 1'b0);

    for (int k = 0; k < 5; k++)
      run_frame($sformatf("random%0d", k), 16'($urandom), 16'($urandom_range(1, 5)),
                16'($urandom_range(1, 4)), 16'($urandom), 16'($urandom), 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
